// File: rtl/frame_sched_pkg.sv
// Shared types and VGA timing constants for the per-frame update scheduler.
package frame_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_GRANT = 2'd2
   } state_t;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned CX_W     = 10;
   localparam int unsigned CY_W     = 9;

endpackage

// File: rtl/lowest_set_picker.sv
// Combinational one-hot selector of the lowest set bit, plus an any-set flag.
module lowest_set_picker #(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0] pending,
   output logic [N-1:0] onehot_c,
   output logic         any_c
);

   logic [N-1:0] neg;

   // Two's complement isolates the lowest set bit.
   always_comb begin
      neg      = ~pending + N'(1);
      onehot_c = pending & neg;
      any_c    = |pending;
   end

endmodule

// File: rtl/frame_update_scheduler.sv
// Grants the vertical-blanking update window to one requester at a time in
// fixed priority order, with a per-slot watchdog and a hard close at display.
module frame_update_scheduler
   import frame_sched_pkg::*;
#(
   parameter int unsigned N_REQ           = 3,
   parameter int unsigned V_ACTIVE        = frame_sched_pkg::V_ACTIVE,
   parameter int unsigned MAX_SLOT_CYCLES = 4096,
   parameter int unsigned FC_W            = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CX_W-1:0]  CounterX,
   input  logic [CY_W-1:0]  CounterY,
   input  logic             inDisplayArea,
   input  logic [N_REQ-1:0] upd_req,
   input  logic [N_REQ-1:0] upd_done,
   output logic [N_REQ-1:0] upd_grant,
   output logic             frame_tick,
   output logic             busy,
   output logic [FC_W-1:0]  frame_count,
   output logic             overrun,
   output logic [N_REQ-1:0] skipped_mask,
   output logic [N_REQ-1:0] timeout_mask
);

   localparam int unsigned SC_W = (MAX_SLOT_CYCLES > 1) ? $clog2(MAX_SLOT_CYCLES) : 1;
   localparam logic [SC_W-1:0] SLOT_LAST = SC_W'(MAX_SLOT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [N_REQ-1:0] grant_d, skipped_d, timeout_d;
   logic [SC_W-1:0]  slot_q, slot_d;
   logic [FC_W-1:0]  fc_d;
   logic             frame_tick_d, busy_d, overrun_d;
   logic [N_REQ-1:0] pick_c;
   logic             pick_any_c;
   logic             trigger_c;

   lowest_set_picker #(.N(N_REQ)) u_pick (
      .pending  (pending_q),
      .onehot_c (pick_c),
      .any_c    (pick_any_c)
   );

   assign trigger_c = (CounterY == CY_W'(V_ACTIVE)) && (CounterX == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pending_q    <= '0;
         slot_q       <= '0;
         upd_grant    <= '0;
         frame_tick   <= 1'b0;
         busy         <= 1'b0;
         frame_count  <= '0;
         overrun      <= 1'b0;
         skipped_mask <= '0;
         timeout_mask <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         slot_q       <= slot_d;
         upd_grant    <= grant_d;
         frame_tick   <= frame_tick_d;
         busy         <= busy_d;
         frame_count  <= fc_d;
         overrun      <= overrun_d;
         skipped_mask <= skipped_d;
         timeout_mask <= timeout_d;
      end
   end

   // Next-state and registered-output logic; done beats timeout beats close.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      slot_d       = slot_q;
      grant_d      = upd_grant;
      frame_tick_d = 1'b0;
      fc_d         = frame_count;
      overrun_d    = 1'b0;
      skipped_d    = skipped_mask;
      timeout_d    = timeout_mask;

      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            if (trigger_c) begin
               pending_d    = upd_req;
               frame_tick_d = 1'b1;
               fc_d         = frame_count + FC_W'(1);
               skipped_d    = '0;
               state_d      = S_SCAN;
            end
         end
         S_SCAN: begin
            grant_d = '0;
            if (inDisplayArea) begin
               state_d = S_IDLE;
               if (pick_any_c) begin
                  overrun_d = 1'b1;
                  skipped_d = pending_q;
                  pending_d = '0;
               end
            end else if (!pick_any_c) begin
               state_d = S_IDLE;
            end else begin
               grant_d = pick_c;
               slot_d  = '0;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (slot_q != SLOT_LAST) slot_d = slot_q + SC_W'(1);
            if ((upd_done & upd_grant) != '0) begin
               pending_d = pending_q & ~upd_grant;
               grant_d   = '0;
               state_d   = S_SCAN;
            end else if (slot_q == SLOT_LAST) begin
               timeout_d = timeout_mask | upd_grant;
               pending_d = pending_q & ~upd_grant;
               grant_d   = '0;
               state_d   = S_SCAN;
            end else if (inDisplayArea) begin
               grant_d   = '0;
               overrun_d = 1'b1;
               skipped_d = pending_q;
               pending_d = '0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler with hand-computed expectations.
module tb_frame_update_scheduler;

   logic       clk_tb = 1'b0;
   logic       reset;
   logic [9:0] CounterX;
   logic [8:0] CounterY;
   logic       inDisplayArea;
   logic [2:0] upd_req, upd_done;
   logic [2:0] upd_grant, skipped_mask, timeout_mask;
   logic       frame_tick, busy, overrun;
   logic [15:0] frame_count;

   int total = 0;
   int bad   = 0;
   int ov_cnt = 0;
   int ft_cnt = 0;
   int exp_fc = 0;
   int ov0, ft0;

   always #5 clk_tb = ~clk_tb;

   frame_update_scheduler #(
      .N_REQ(3), .V_ACTIVE(480), .MAX_SLOT_CYCLES(16), .FC_W(16)
   ) dut (
      .clk           (clk_tb),
      .reset         (reset),
      .CounterX      (CounterX),
      .CounterY      (CounterY),
      .inDisplayArea (inDisplayArea),
      .upd_req       (upd_req),
      .upd_done      (upd_done),
      .upd_grant     (upd_grant),
      .frame_tick    (frame_tick),
      .busy          (busy),
      .frame_count   (frame_count),
      .overrun       (overrun),
      .skipped_mask  (skipped_mask),
      .timeout_mask  (timeout_mask)
   );

   always @(negedge clk_tb) begin
      if (overrun)    ov_cnt++;
      if (frame_tick) ft_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs and checks land 1 time unit after the edge.
   task automatic tick();
      @(posedge clk_tb);
      #1;
   endtask

   task automatic trigger();
      CounterY = 9'd480;
      CounterX = 10'd0;
      tick();
      CounterY = 9'd100;
      CounterX = 10'd5;
      exp_fc++;
   endtask

   initial begin
      reset = 1'b1; CounterX = 10'd5; CounterY = 9'd0; inDisplayArea = 1'b0;
      upd_req = 3'b000; upd_done = 3'b000;
      tick(); tick();
      check("rst_grant", 32'(upd_grant), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_fc", 32'(frame_count), 0);
      check("rst_tick", 32'(frame_tick), 0);
      check("rst_ov", 32'(overrun), 0);
      check("rst_masks", 32'({skipped_mask, timeout_mask}), 0);
      reset = 1'b0;
      tick();

      // 1: two requesters, each done 10 cycles after its grant
      ov0 = ov_cnt; ft0 = ft_cnt;
      upd_req = 3'b101;
      trigger();
      check("t1_tick", 32'(frame_tick), 1);
      check("t1_fc", 32'(frame_count), 32'(exp_fc));
      check("t1_busy", 32'(busy), 1);
      check("t1_gr_T1", 32'(upd_grant), 0);
      tick();
      check("t1_gr0", 32'(upd_grant), 32'b001);
      check("t1_tick_off", 32'(frame_tick), 0);
      for (int i = 0; i < 9; i++) tick();
      check("t1_gr0_hold", 32'(upd_grant), 32'b001);
      upd_done = 3'b001; tick(); upd_done = 3'b000;
      check("t1_gap", 32'(upd_grant), 0);
      check("t1_gap_busy", 32'(busy), 1);
      tick();
      check("t1_gr2", 32'(upd_grant), 32'b100);
      for (int i = 0; i < 9; i++) tick();
      upd_done = 3'b100; tick(); upd_done = 3'b000;
      check("t1_gr_off", 32'(upd_grant), 0);
      tick();
      check("t1_busy_end", 32'(busy), 0);
      check("t1_ov_cnt", 32'(ov_cnt - ov0), 0);
      check("t1_ft_cnt", 32'(ft_cnt - ft0), 1);

      // 2: watchdog force-release after 16 granted cycles
      ov0 = ov_cnt;
      upd_req = 3'b010;
      trigger(); tick();
      check("t2_gr", 32'(upd_grant), 32'b010);
      for (int i = 0; i < 15; i++) tick();
      check("t2_gr_last", 32'(upd_grant), 32'b010);
      tick();
      check("t2_gr_drop", 32'(upd_grant), 0);
      check("t2_timeout", 32'(timeout_mask), 32'b010);
      tick();
      check("t2_busy", 32'(busy), 0);
      check("t2_ov_cnt", 32'(ov_cnt - ov0), 0);

      // 3: window closes while requester 0 holds the grant
      upd_req = 3'b111;
      trigger(); tick();
      check("t3_gr", 32'(upd_grant), 32'b001);
      tick(); tick();
      inDisplayArea = 1'b1; tick();
      check("t3_gr_drop", 32'(upd_grant), 0);
      check("t3_ov", 32'(overrun), 1);
      check("t3_skip", 32'(skipped_mask), 32'b111);
      check("t3_busy", 32'(busy), 0);
      tick();
      check("t3_ov_pulse", 32'(overrun), 0);
      check("t3_skip_hold", 32'(skipped_mask), 32'b111);
      inDisplayArea = 1'b0;

      // 4: empty frame; also clears skipped_mask at frame_tick
      upd_req = 3'b000;
      trigger();
      check("t4_tick", 32'(frame_tick), 1);
      check("t4_skip_clr", 32'(skipped_mask), 0);
      check("t4_busy_on", 32'(busy), 1);
      check("t4_fc", 32'(frame_count), 32'(exp_fc));
      tick();
      check("t4_busy_off", 32'(busy), 0);
      check("t4_gr", 32'(upd_grant), 0);

      // 5: stray done on another index and late request are ignored
      upd_req = 3'b001;
      trigger(); tick();
      check("t5_gr", 32'(upd_grant), 32'b001);
      upd_done = 3'b100; upd_req = 3'b011; tick(); upd_done = 3'b000;
      check("t5_stray", 32'(upd_grant), 32'b001);
      tick();
      upd_done = 3'b001; tick(); upd_done = 3'b000;
      tick();
      check("t5_no_late", 32'(upd_grant), 0);
      check("t5_idle", 32'(busy), 0);
      trigger(); tick();
      check("t5_nf_gr0", 32'(upd_grant), 32'b001);
      upd_done = 3'b001; tick(); upd_done = 3'b000;
      tick();
      check("t5_nf_gr1", 32'(upd_grant), 32'b010);
      upd_done = 3'b010; tick(); upd_done = 3'b000;
      tick();
      check("t5_end", 32'(busy), 0);

      // 6a: done coincides with window close
      ov0 = ov_cnt;
      upd_req = 3'b011;
      trigger(); tick();
      check("t6_gr", 32'(upd_grant), 32'b001);
      upd_done = 3'b001; inDisplayArea = 1'b1; tick(); upd_done = 3'b000;
      check("t6_credit", 32'(upd_grant), 0);
      check("t6_no_ov_yet", 32'(overrun), 0);
      tick();
      check("t6_ov", 32'(overrun), 1);
      check("t6_skip", 32'(skipped_mask), 32'b010);
      check("t6_gr_zero", 32'(upd_grant), 0);
      inDisplayArea = 1'b0;
      tick();

      // 6b: reset mid-grant
      upd_req = 3'b001;
      trigger(); tick();
      check("t6b_gr", 32'(upd_grant), 32'b001);
      ov0 = ov_cnt;
      reset = 1'b1; tick(); exp_fc = 0;
      check("t6b_gr", 32'(upd_grant), 0);
      check("t6b_busy", 32'(busy), 0);
      check("t6b_fc", 32'(frame_count), 32'(exp_fc));
      check("t6b_masks", 32'({skipped_mask, timeout_mask}), 0);
      check("t6b_ov", 32'(overrun), 0);
      reset = 1'b0; tick();
      check("t6b_ov_cnt", 32'(ov_cnt - ov0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
